// File: rtl/keypad_col_scanner_if.sv
// keypad_col_scanner_if: keypad pin, row-flag and decoded-key signals of the column scanner.
interface keypad_col_scanner_if;
    logic [3:0] Row;
    logic       S_Row;
    logic [3:0] Col;
    logic [3:0] Code;
    logic       Valid;
    logic       Held;
    modport master (output Row, S_Row, input Col, Code, Valid, Held);
    modport slave  (input Row, S_Row, output Col, Code, Valid, Held);
endinterface

// File: rtl/keypad_col_scanner.sv
// keypad_col_scanner: debounces keypad press/release and walks the columns to locate the key.
module keypad_col_scanner #(
    parameter int DEBOUNCE = 4,
    parameter int DWELL    = 3
) (
    input logic                  clock,
    input logic                  reset,
    keypad_col_scanner_if.slave  kp
);
    localparam int DB_W = $clog2(DEBOUNCE + 1);
    localparam int DW_W = $clog2(DWELL);
    typedef enum logic [2:0] {IDLE, PRESS_DB, SCAN, KEY_HELD, RELEASE_DB} state_t;
    state_t          state, state_nx;
    logic [DB_W-1:0] db_cnt, db_nx;
    logic [DW_W-1:0] dwell, dwell_nx;
    logic [1:0]      col_idx, col_nx, row_idx;
    logic [3:0]      row_s1, row_s2, code_nx;
    logic            valid_nx, held_nx, hit, db_done, dwell_done;
    assign row_idx    = row_s2[0] ? 2'd0 : row_s2[1] ? 2'd1 : row_s2[2] ? 2'd2 : 2'd3;
    // an S_Row flag with no synchronized row bit cannot be decoded, so it counts as no key
    assign hit        = kp.S_Row && |row_s2;
    assign db_done    = db_cnt >= DB_W'(DEBOUNCE - 1);
    assign dwell_done = dwell == DW_W'(DWELL - 1);
    assign kp.Col     = (state == SCAN) ? 4'b0001 << col_idx : 4'b1111;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            db_cnt   <= '0;
            dwell    <= '0;
            col_idx  <= '0;
            row_s1   <= '0;
            row_s2   <= '0;
            kp.Code  <= '0;
            kp.Valid <= 1'b0;
            kp.Held  <= 1'b0;
        end else begin
            state    <= state_nx;
            db_cnt   <= db_nx;
            dwell    <= dwell_nx;
            col_idx  <= col_nx;
            row_s1   <= kp.Row;
            row_s2   <= row_s1;
            kp.Code  <= code_nx;
            kp.Valid <= valid_nx;
            kp.Held  <= held_nx;
        end
    end
    always_comb begin
        state_nx = state;
        db_nx    = db_cnt;
        dwell_nx = dwell;
        col_nx   = col_idx;
        code_nx  = kp.Code;
        valid_nx = 1'b0;
        held_nx  = kp.Held;
        case (state)
            IDLE: if (kp.S_Row) begin
                state_nx = PRESS_DB;
                db_nx    = DB_W'(1);
            end
            PRESS_DB: begin
                if (!kp.S_Row) begin
                    state_nx = IDLE;
                    db_nx    = '0;
                end else if (db_done) begin
                    state_nx = SCAN;
                    db_nx    = '0;
                    col_nx   = '0;
                    dwell_nx = '0;
                end else
                    db_nx = db_cnt + DB_W'(1);
            end
            SCAN: begin
                dwell_nx = dwell_done ? '0 : dwell + DW_W'(1);
                if (dwell_done && hit) begin
                    state_nx = KEY_HELD;
                    code_nx  = {row_idx, col_idx};
                    valid_nx = 1'b1;
                    held_nx  = 1'b1;
                end else if (dwell_done && col_idx != 2'd3)
                    col_nx = col_idx + 2'd1;
                else if (dwell_done)
                    state_nx = IDLE;
            end
            KEY_HELD: if (!kp.S_Row) begin
                state_nx = RELEASE_DB;
                db_nx    = DB_W'(1);
            end
            RELEASE_DB: begin
                if (kp.S_Row) begin
                    state_nx = KEY_HELD;
                    db_nx    = '0;
                end else if (db_done) begin
                    state_nx = IDLE;
                    db_nx    = '0;
                    held_nx  = 1'b0;
                end else
                    db_nx = db_cnt + DB_W'(1);
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_keypad_col_scanner.sv
// tb_keypad_col_scanner: keypad matrix model plus negedge row-flag sync, scoreboarded key codes.
module tb_keypad_col_scanner;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [3:0][3:0] keys = '0;
    logic s1 = 1'b0, s2 = 1'b0;
    logic [3:0] sb[$];
    int n_checks = 0, n_fail = 0, n_valid = 0;
    keypad_col_scanner_if kif ();
    keypad_col_scanner dut (.clock(clock), .reset(reset), .kp(kif));
    always #5 clock = ~clock;
    always_comb for (int r = 0; r < 4; r++) kif.Row[r] = |(keys[r] & kif.Col);
    always @(negedge clock) begin
        s1 <= |kif.Row;
        s2 <= s1;
    end
    assign kif.S_Row = s2;
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    function automatic logic [3:0] model(input logic [3:0][3:0] k);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (k[r][c]) return {r[1:0], c[1:0]};
        return 4'h0;
    endfunction
    always @(negedge clock) begin
        if (reset && kif.Valid) check("valid_in_reset", 1, 0);
        else if (kif.Valid) begin
            n_valid++;
            if (sb.size() == 0) check("unexpected_valid", {28'h0, kif.Code}, 32'hdead);
            else check("valid_code", kif.Code, sb.pop_front());
        end
    end
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask
    task automatic wait_held(input logic v, input string nm, output int cyc);
        cyc = 0;
        while (cyc < 60 && kif.Held !== v) begin
            tick(1);
            cyc++;
        end
        check(nm, kif.Held, v);
    endtask
    task automatic wait_col(input logic [3:0] v, input string nm);
        int i = 0;
        while (i < 60 && kif.Col !== v) begin
            @(negedge clock);
            i++;
        end
        check(nm, kif.Col, v);
    endtask
    initial begin
        int cyc, nv;
        logic [3:0] hist[$];
        logic bad, seen3;
        tick(3);
        check("rst_col", kif.Col, 4'hf);
        check("rst_code", kif.Code, 0);
        check("rst_valid", kif.Valid, 0);
        check("rst_held", kif.Held, 0);
        reset = 1'b0;
        tick(2);
        // row1/col2
        nv = n_valid;
        sb.push_back(4'h6);
        keys[1][2] = 1'b1;
        wait_held(1, "t2_held", cyc);
        check("t2_latency", cyc <= 4 + 17, 1);
        tick(3);
        check("t2_one_valid", n_valid - nv, 1);
        keys = '0;
        wait_held(0, "t2_release", cyc);
        tick(3);
        // row3/col3 with column walk capture
        sb.push_back(4'hf);
        keys[3][3] = 1'b1;
        cyc = 0;
        do begin
            @(negedge clock);
            hist.push_back(kif.Col);
            cyc++;
        end while (!kif.Valid && cyc < 60);
        check("t3_valid_seen", kif.Valid, 1);
        while (hist.size() > 0 && hist[0] == 4'hf) void'(hist.pop_front());
        check("t3_seq_len", hist.size(), 13);
        if (hist.size() == 13) begin
            for (int i = 0; i < 12; i++) check("t3_col_seq", hist[i], 4'b0001 << (i / 3));
            check("t3_col_after", hist[12], 4'hf);
        end
        #1;
        keys = '0;
        wait_held(0, "t3_release", cyc);
        tick(3);
        // press bounce shorter than debounce
        nv = n_valid;
        keys[0][0] = 1'b1;
        tick(3);
        keys = '0;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clock);
            if (kif.Col !== 4'hf) bad = 1'b1;
        end
        #1;
        check("t4_col_idle", bad, 0);
        check("t4_no_valid", n_valid - nv, 0);
        // release bounce
        nv = n_valid;
        sb.push_back(4'h8);
        keys[2][0] = 1'b1;
        wait_held(1, "t5_held", cyc);
        tick(3);
        keys = '0;
        tick(2);
        keys[2][0] = 1'b1;
        tick(8);
        check("t5_held_bounce", kif.Held, 1);
        check("t5_one_valid", n_valid - nv, 1);
        keys = '0;
        tick(4);
        check("t5_held_3low", kif.Held, 1);
        tick(1);
        check("t5_held_4low", kif.Held, 0);
        tick(3);
        // key lost during scan
        nv = n_valid;
        keys[0][2] = 1'b1;
        wait_col(4'b0010, "t6_reach_col1");
        #2;
        keys = '0;
        seen3 = 1'b0;
        repeat (30) begin
            @(negedge clock);
            if (kif.Col === 4'b1000) seen3 = 1'b1;
        end
        #1;
        check("t6_col3_seen", seen3, 1);
        check("t6_col_idle", kif.Col, 4'hf);
        check("t6_no_valid", n_valid - nv, 0);
        check("t6_code_kept", kif.Code, 4'h8);
        check("t6_held", kif.Held, 0);
        // reset mid-scan
        keys[0][3] = 1'b1;
        wait_col(4'b0010, "t1_reach_col1");
        #2;
        reset = 1'b1;
        #1;
        check("t1_col", kif.Col, 4'hf);
        check("t1_valid", kif.Valid, 0);
        check("t1_held", kif.Held, 0);
        check("t1_code", kif.Code, 0);
        keys = '0;
        tick(4);
        reset = 1'b0;
        tick(4);
        check("t1_idle_after", kif.Col, 4'hf);
        // randomized presses, multi-key presses, extra keys while held, short bounces
        for (int it = 0; it < 40; it++) begin
            int mode;
            mode = $urandom_range(0, 3);
            nv = n_valid;
            if (mode == 0) begin
                keys[$urandom_range(0, 3)][$urandom_range(0, 3)] = 1'b1;
                tick($urandom_range(1, 3));
                keys = '0;
                tick(15);
                check("rnd_bounce_no_valid", n_valid - nv, 0);
            end else begin
                keys[$urandom_range(0, 3)][$urandom_range(0, 3)] = 1'b1;
                if (mode == 3) keys[$urandom_range(0, 3)][$urandom_range(0, 3)] = 1'b1;
                sb.push_back(model(keys));
                wait_held(1, "rnd_held", cyc);
                if ($urandom_range(0, 1) == 1) begin
                    tick($urandom_range(1, 4));
                    keys[$urandom_range(0, 3)][$urandom_range(0, 3)] = 1'b1;
                end
                tick($urandom_range(2, 15));
                keys = '0;
                wait_held(0, "rnd_release", cyc);
                tick($urandom_range(1, 6));
                check("rnd_one_valid", n_valid - nv, 1);
            end
        end
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
